// File: rtl/alu_operand_stage.sv
// Decode/operand stage ahead of the ALU: register file, operand select,
// and a single-entry valid/ready output buffer.
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  localparam int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_rd,
  input  logic             flush,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_op,
  output logic [AW-1:0]    out_rd
);

  logic [WIDTH-1:0] rf [NREG];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] reg_b;
  logic [WIDTH-1:0] op_b;
  logic             accept;
  logic             wb_hit;

  assign wb_hit = wb_en && (wb_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_hit) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Same-cycle write-back wins over the stale array value.
  always_comb begin
    op_a = rf[in_rs1];
    if (in_rs1 == '0)
      op_a = '0;
    else if (wb_hit && wb_addr == in_rs1)
      op_a = wb_data;
    reg_b = rf[in_rs2];
    if (in_rs2 == '0)
      reg_b = '0;
    else if (wb_hit && wb_addr == in_rs2)
      reg_b = wb_data;
    op_b = in_use_imm ? in_imm : reg_b;
  end

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= 3'b000;
      out_rd    <= '0;
    end else begin
      priority case (1'b1)
        flush: out_valid <= 1'b0;
        accept: begin
          out_valid <= 1'b1;
          out_a     <= op_a;
          out_b     <= op_b;
          out_op    <= in_op;
          out_rd    <= in_rd;
        end
        out_ready: out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected bundles are queued on
// accept and compared as the ALU side consumes them.
module tb_alu_operand_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 0;
  logic        rst = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [4:0]  in_rs1 = 0;
  logic [4:0]  in_rs2 = 0;
  logic [31:0] in_imm = 0;
  logic        in_use_imm = 0;
  logic [2:0]  in_op = 0;
  logic [4:0]  in_rd = 0;
  logic        flush = 0;
  logic        wb_en = 0;
  logic [4:0]  wb_addr = 0;
  logic [31:0] wb_data = 0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_op;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int cyc = 0;
  exp_t sb[$];
  exp_t mon_e;

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_op(in_op), .in_rd(in_rd),
    .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_rd(out_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  // Consumer side: every handshaken output must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && !flush) begin
      checks++;
      pops++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: unexpected a=%h b=%h op=%b rd=%0d",
                 out_a, out_b, out_op, out_rd);
      end else begin
        mon_e = sb.pop_front();
        if ({out_a, out_b, out_op, out_rd} !== mon_e) begin
          errors++;
          $display("FAIL sb_data: got a=%h b=%h op=%b rd=%0d want a=%h b=%h op=%b rd=%0d",
                   out_a, out_b, out_op, out_rd,
                   mon_e.a, mon_e.b, mon_e.op, mon_e.rd);
        end
      end
    end
  end

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_en = 0;
  endtask

  task automatic send(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input logic ui,
                      input logic [2:0] op, input logic [4:0] rd,
                      input logic [31:0] ea, input logic [31:0] eb);
    exp_t e;
    in_valid = 1; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_use_imm = ui; in_op = op; in_rd = rd;
    e.a = ea; e.b = eb; e.op = op; e.rd = rd;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        sb.push_back(e);
        #1;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_timeout: in_ready=%b want 1 within 20 cycles", in_ready);
  endtask

  task automatic idle();
    in_valid = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_a, out_b, out_op, out_rd} !== 73'd0) begin
      errors++;
      $display("FAIL reset_out: got v=%b a=%h b=%h op=%b rd=%0d want all 0",
               out_valid, out_a, out_b, out_op, out_rd);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", in_ready);
    end
    rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    wb(5'd5, 32'h0000_0007);
    wb(5'd6, 32'hFFFF_FFFD);
    wb(5'd31, 32'h8000_0000);
    send(5'd5, 5'd6, 32'h0, 1'b0, 3'b010, 5'd1, 32'h7, 32'hFFFF_FFFD);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: out_valid=%b want 1", out_valid);
    end
    idle();
  endtask

  task automatic test_bypass();
    wb_en = 1; wb_addr = 5'd9; wb_data = 32'h1234_5678;
    send(5'd9, 5'd0, 32'h0, 1'b0, 3'b000, 5'd2, 32'h1234_5678, 32'h0);
    wb_en = 0;
    send(5'd9, 5'd5, 32'h0, 1'b0, 3'b001, 5'd4, 32'h1234_5678, 32'h7);
    idle();
  endtask

  task automatic test_zero();
    wb(5'd0, 32'hDEAD_BEEF);
    send(5'd0, 5'd0, 32'hFFFF_FFF0, 1'b1, 3'b110, 5'd3, 32'h0, 32'hFFFF_FFF0);
    wb_en = 1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    send(5'd0, 5'd0, 32'h0, 1'b0, 3'b111, 5'd7, 32'h0, 32'h0);
    wb_en = 0;
    idle();
  endtask

  task automatic test_stall();
    out_ready = 0;
    send(5'd5, 5'd31, 32'h0, 1'b0, 3'b010, 5'd8, 32'h7, 32'h8000_0000);
    in_valid = 1; in_rs1 = 5'd6; in_rs2 = 5'd5; in_op = 3'b110; in_rd = 5'd9;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hs: in_ready=%b out_valid=%b want 0 1",
                 in_ready, out_valid);
      end
      checks++;
      if ({out_a, out_b, out_op, out_rd} !==
          {32'h7, 32'h8000_0000, 3'b010, 5'd8}) begin
        errors++;
        $display("FAIL stall_hold: got a=%h b=%h op=%b rd=%0d want 7 80000000 010 8",
                 out_a, out_b, out_op, out_rd);
      end
      @(posedge clk); #1;
    end
    out_ready = 1;
    send(5'd6, 5'd5, 32'h0, 1'b0, 3'b110, 5'd9, 32'hFFFF_FFFD, 32'h7);
    idle();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: queue=%0d out_valid=%b want 0 0",
               sb.size(), out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    int c0;
    p0 = pops;
    c0 = cyc;
    send(5'd5, 5'd6, 32'h0, 1'b0, 3'b000, 5'd10, 32'h7, 32'hFFFF_FFFD);
    send(5'd6, 5'd31, 32'h0, 1'b0, 3'b001, 5'd11, 32'hFFFF_FFFD, 32'h8000_0000);
    send(5'd31, 5'd0, 32'h5, 1'b1, 3'b111, 5'd12, 32'h8000_0000, 32'h5);
    send(5'd9, 5'd5, 32'h0, 1'b0, 3'b101, 5'd31, 32'h1234_5678, 32'h7);
    idle();
    checks++;
    if (pops - p0 != 4 || cyc - c0 != 5) begin
      errors++;
      $display("FAIL b2b_rate: got %0d outputs in %0d cycles want 4 in 5",
               pops - p0, cyc - c0);
    end
  endtask

  task automatic test_flush();
    out_ready = 0;
    send(5'd5, 5'd6, 32'h0, 1'b0, 3'b010, 5'd13, 32'h7, 32'hFFFF_FFFD);
    in_valid = 1; in_rs1 = 5'd9; in_rs2 = 5'd9; in_rd = 5'd14;
    flush = 1;
    wb_en = 1; wb_addr = 5'd12; wb_data = 32'hAAAA_5555;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready: got %b want 0", in_ready);
    end
    @(posedge clk); #1;
    flush = 0; in_valid = 0; wb_en = 0;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_kill: out_valid=%b want 0", out_valid);
    end
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_drop: out_valid=%b want 0", out_valid);
    end
    send(5'd12, 5'd0, 32'h0, 1'b0, 3'b000, 5'd15, 32'hAAAA_5555, 32'h0);
    idle();
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    send(5'd5, 5'd6, 32'h0, 1'b0, 3'b010, 5'd16, 32'h7, 32'hFFFF_FFFD);
    in_valid = 0;
    @(posedge clk); #2;
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_a !== 32'h0) begin
      errors++;
      $display("FAIL rst_async: out_valid=%b out_a=%h want 0 0", out_valid, out_a);
    end
    sb.delete();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    out_ready = 1;
    send(5'd5, 5'd12, 32'h0, 1'b0, 3'b010, 5'd17, 32'h0, 32'h0);
    idle();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_bypass();
    test_zero();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d outputs never seen want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
